// File: rtl/image_sram_ctrl_if.sv
// Bus bundle between the tile-buffer controller and its neighbours: pixel input
// stream, conv-engine output stream, read command/status and the image_SRAM port.
interface image_sram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rd_start;
  logic              loaded;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              done;
  logic              sram_cs;
  logic              sram_we;
  logic              sram_rd;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  // Controller side.
  modport master (
    input  in_data, in_valid, rd_start, out_ready, sram_dout,
    output in_ready, loaded, out_data, out_valid, out_last, done,
    output sram_cs, sram_we, sram_rd, sram_addr, sram_din
  );

  // Environment side: pixel source, conv engine and the SRAM itself.
  modport slave (
    output in_data, in_valid, rd_start, out_ready, sram_dout,
    input  in_ready, loaded, out_data, out_valid, out_last, done,
    input  sram_cs, sram_we, sram_rd, sram_addr, sram_din
  );
endinterface

// File: rtl/image_sram_ctrl.sv
// Tile buffer controller: writes one tile of pixels into image_SRAM, then on
// rd_start streams it back in address order through a 2-entry skid FIFO.
module image_sram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  image_sram_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, LOADED, READ} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_all;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] head_data, tail_data;
  logic              head_last, tail_last;
  logic              done_q;

  logic wr_en, wr_last, rd_issue, push, pop, last_pop;

  assign wr_en    = ((state == IDLE) || (state == LOAD)) && bus.in_valid;
  assign wr_last  = (wr_ptr == LAST_ADDR);
  assign push     = inflight;
  assign pop      = (fifo_count != 2'd0) && bus.out_ready;
  assign last_pop = pop && head_last;

  // A read may issue only if the data it returns is guaranteed a FIFO slot,
  // counting the read already in flight and any beat leaving this cycle.
  always_comb begin
    rd_issue = (state == READ) && !rd_all &&
               (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid) next_state = wr_last ? LOADED : LOAD;
      LOAD:    if (bus.in_valid && wr_last) next_state = LOADED;
      LOADED:  if (bus.rd_start) next_state = READ;
      READ:    if (last_pop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) || (state == LOAD);
    bus.loaded    = (state == LOADED);
    bus.sram_we   = wr_en;
    bus.sram_rd   = rd_issue;
    bus.sram_cs   = wr_en | rd_issue;
    bus.sram_addr = '0;
    bus.sram_din  = '0;
    if (wr_en) begin
      bus.sram_addr = wr_ptr;
      bus.sram_din  = bus.in_data;
    end else if (rd_issue) begin
      bus.sram_addr = rd_ptr;
    end
    bus.out_valid = (fifo_count != 2'd0);
    bus.out_data  = head_data;
    bus.out_last  = (fifo_count != 2'd0) && head_last;
    bus.done      = done_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_last ? '0 : wr_ptr + ADDR_W'(1);
    end
  end

  // rd_all marks that address DEPTH-1 has been issued, so rd_ptr never has to
  // step past the end of the tile.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr        <= '0;
      rd_all        <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && (rd_ptr == LAST_ADDR);
      if ((state == LOADED && bus.rd_start) || last_pop) begin
        rd_ptr <= '0;
        rd_all <= 1'b0;
      end else if (rd_issue) begin
        if (rd_ptr == LAST_ADDR) rd_all <= 1'b1;
        else                     rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fifo_count <= 2'd0;
      head_data  <= '0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            head_data <= bus.sram_dout;
            head_last <= inflight_last;
          end else begin
            tail_data <= bus.sram_dout;
            tail_last <= inflight_last;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          head_data  <= tail_data;
          head_last  <= tail_last;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            head_data <= bus.sram_dout;
            head_last <= inflight_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= bus.sram_dout;
            tail_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) done_q <= 1'b0;
    else        done_q <= last_pop;
  end

  a_we_rd_exclusive: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(bus.sram_we && bus.sram_rd));

  a_fifo_bound: assert property (@(posedge Clk) disable iff (!Rst_n)
    ({1'b0, fifo_count} + {2'b00, inflight}) <= 3'd2);

  a_stall_stable: assert property (@(posedge Clk) disable iff (!Rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_image_sram_ctrl.sv
// Randomised scoreboard bench for image_sram_ctrl: a pixel-order reference model
// predicts every SRAM write and output beat; a second build covers DEPTH=1.
module tb_image_sram_ctrl;

  localparam int DEPTH = 16;

  logic Clk = 1'b0;
  logic Rst_n = 1'b1;

  int total = 0;
  int bad = 0;

  image_sram_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  image_sram_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus1 ();

  image_sram_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus.master));

  image_sram_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus1.master));

  initial forever #5 Clk = ~Clk;

  // Behavioural image_SRAM: write on CS&WE, registered read on CS&RD.
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  always @(posedge Clk) begin
    if (bus.sram_cs && bus.sram_we) mem0[bus.sram_addr] <= bus.sram_din;
    if (bus.sram_cs && bus.sram_rd) bus.sram_dout <= mem0[bus.sram_addr];
    if (bus1.sram_cs && bus1.sram_we) mem1[bus1.sram_addr] <= bus1.sram_din;
    if (bus1.sram_cs && bus1.sram_rd) bus1.sram_dout <= mem1[bus1.sram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: event did not happen at %0t", name, $time);
  endtask

  // Reference model: phase 0 = filling, 1 = full, 2 = draining.
  logic [8:0] expQ [$];
  logic [8:0] expQ1 [$];
  int   phase = 0, fillCount = 0, popCount = 0, readsIssued = 0, beats1 = 0;
  logic donePending = 1'b0, prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  always @(negedge Clk) begin : monitor
    int curPhase;
    logic doneNext, popNow;
    logic [8:0] head;
    if (!Rst_n) begin
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_loaded", 32'(bus.loaded), 32'd0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_sram_ctl", 32'({bus.sram_cs, bus.sram_we, bus.sram_rd}), 32'd0);
      checkOutput("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
      checkOutput("rst_sram_din", 32'(bus.sram_din), 32'd0);
      expQ.delete();
      phase = 0; fillCount = 0; popCount = 0; readsIssued = 0;
      donePending = 1'b0; prevStall = 1'b0;
    end else begin
      curPhase = phase;
      doneNext = 1'b0;
      checkOutput("done", 32'(bus.done), 32'(donePending));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(curPhase == 0));
      checkOutput("loaded", 32'(bus.loaded), 32'(curPhase == 1));
      checkOutput("cs_is_we_or_rd", 32'(bus.sram_cs), 32'(bus.sram_we | bus.sram_rd));
      checkOutput("we_rd_exclusive", 32'(bus.sram_we & bus.sram_rd), 32'd0);
      checkOutput("sram_we", 32'(bus.sram_we), 32'(bus.in_valid && curPhase == 0));
      if (bus.in_valid && curPhase == 0) begin
        checkOutput("wr_addr", 32'(bus.sram_addr), 32'(fillCount));
        checkOutput("wr_data", 32'(bus.sram_din), 32'(bus.in_data));
        expQ.push_back({fillCount == DEPTH - 1, bus.in_data});
        fillCount++;
        if (fillCount == DEPTH) begin
          fillCount = 0;
          phase = 1;
        end
      end
      if (curPhase != 2) begin
        checkOutput("out_valid_quiet", 32'(bus.out_valid), 32'd0);
        checkOutput("sram_rd_quiet", 32'(bus.sram_rd), 32'd0);
      end else begin
        if (bus.sram_rd) begin
          checkOutput("rd_addr", 32'(bus.sram_addr), 32'(readsIssued));
          readsIssued++;
        end
        if (prevStall) begin
          checkOutput("stall_valid_held", 32'(bus.out_valid), 32'd1);
          checkOutput("stall_data_stable", 32'(bus.out_data), 32'(prevData));
        end
        popNow = bus.out_valid && bus.out_ready;
        if (popNow) begin
          if (expQ.size() == 0) failNow("beat_expected");
          else begin
            head = expQ.pop_front();
            checkOutput("out_data", 32'(bus.out_data), 32'(head[7:0]));
            checkOutput("out_last", 32'(bus.out_last), 32'(head[8]));
          end
          popCount++;
        end
        checkOutput("reads_ahead_le2", 32'((readsIssued - popCount) <= 2), 32'd1);
        prevStall = bus.out_valid && !bus.out_ready;
        prevData  = bus.out_data;
        if (popNow && popCount == DEPTH) begin
          phase = 0; popCount = 0; readsIssued = 0; prevStall = 1'b0;
          doneNext = 1'b1;
        end
      end
      if (curPhase == 1 && bus.rd_start) begin
        phase = 2; popCount = 0; readsIssued = 0; prevStall = 1'b0;
      end
      donePending = doneNext;
    end
  end

  always @(negedge Clk) begin : monitor1
    logic [8:0] head1;
    if (Rst_n) begin
      checkOutput("d1_cs_is_we_or_rd", 32'(bus1.sram_cs), 32'(bus1.sram_we | bus1.sram_rd));
      if (bus1.out_valid && bus1.out_ready) begin
        if (expQ1.size() == 0) failNow("d1_beat_expected");
        else begin
          head1 = expQ1.pop_front();
          checkOutput("d1_out_data", 32'(bus1.out_data), 32'(head1[7:0]));
          checkOutput("d1_out_last", 32'(bus1.out_last), 32'(head1[8]));
          beats1++;
        end
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1,0,1, 2 = random.
  int readyMode = 0;
  initial begin
    int pidx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge Clk); #1;
      case (readyMode)
        1:       bus.out_ready = ((pidx % 6) inside {0, 3, 5});
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      pidx++;
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rs, output logic acc);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_start = rs;
    @(negedge Clk);
    acc = v && bus.in_ready;
    @(posedge Clk); #1;
  endtask

  task automatic loadTile(input logic [7:0] base, input bit randData, input bit gaps, input bit rdNoise);
    logic acc;
    logic [7:0] d;
    int tries;
    for (int i = 0; i < DEPTH; i++) begin
      if (gaps)
        repeat ($urandom_range(0, 2))
          applyStimulus(1'b0, 8'($urandom), rdNoise ? 1'($urandom_range(0, 1)) : 1'b0, acc);
      d = randData ? 8'($urandom) : base + 8'(i);
      tries = 0;
      do begin
        applyStimulus(1'b1, d, 1'b0, acc);
        tries++;
      end while (!acc && tries < 400);
      if (!acc) begin
        failNow("load_accept_timeout");
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitLoaded();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus.loaded && n < 50);
    if (!bus.loaded) failNow("loaded_timeout");
    @(posedge Clk); #1;
  endtask

  task automatic startRead();
    logic acc;
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    bus.rd_start = 1'b0;
  endtask

  task automatic waitDone(output int cyc, output int firstValid);
    cyc = 0;
    firstValid = 0;
    do begin
      @(negedge Clk);
      cyc++;
      if (bus.out_valid && firstValid == 0) firstValid = cyc;
    end while (!bus.done && cyc < 400);
    if (!bus.done) failNow("done_timeout");
    @(posedge Clk); #1;
  endtask

  initial begin : watchdog
    #300000;
    failNow("global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc, fv, n;
    logic acc;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.rd_start = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.rd_start = 1'b0; bus1.out_ready = 1'b1;
    #2 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;

    $display("[TB] sequential tile, full-rate drain");
    readyMode = 0;
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    loadTile(8'h10, 1'b0, 1'b0, 1'b0);
    waitLoaded();
    startRead();
    waitDone(cyc, fv);
    checkOutput("first_valid_latency", 32'(fv), 32'd3);
    checkOutput("drain_cycles", 32'(cyc), 32'(DEPTH + 3));
    checkOutput("queue_drained_t1", 32'(expQ.size()), 32'd0);

    $display("[TB] patterned backpressure");
    readyMode = 1;
    loadTile(8'h00, 1'b1, 1'b0, 1'b0);
    waitLoaded();
    startRead();
    waitDone(cyc, fv);
    checkOutput("queue_drained_t2", 32'(expQ.size()), 32'd0);

    $display("[TB] gappy input, stray rd_start and in_valid");
    readyMode = 2;
    loadTile(8'h00, 1'b1, 1'b1, 1'b1);
    waitLoaded();
    repeat (3) applyStimulus(1'b1, 8'($urandom), 1'b0, acc);
    bus.in_valid = 1'b0;
    startRead();
    waitDone(cyc, fv);
    checkOutput("queue_drained_t3", 32'(expQ.size()), 32'd0);

    $display("[TB] reset during read");
    readyMode = 1;
    loadTile(8'h30, 1'b0, 1'b0, 1'b0);
    waitLoaded();
    startRead();
    n = 0;
    while (popCount < 7 && n < 200) begin
      @(posedge Clk);
      n++;
    end
    if (popCount < 7) failNow("beat7_timeout");
    #1 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk); #1;
    loadTile(8'hA0, 1'b0, 1'b0, 1'b0);
    waitLoaded();
    startRead();
    waitDone(cyc, fv);
    checkOutput("queue_drained_t4", 32'(expQ.size()), 32'd0);

    $display("[TB] back-to-back tiles");
    readyMode = 0;
    loadTile(8'h00, 1'b1, 1'b0, 1'b0);
    waitLoaded();
    for (int t = 0; t < 3; t++) begin
      startRead();
      fork
        waitDone(cyc, fv);
        loadTile(8'h00, 1'b1, 1'b0, 1'b0);
      join
      checkOutput("b2b_drain_cycles", 32'(cyc), 32'(DEPTH + 3));
      waitLoaded();
    end
    readyMode = 2;
    startRead();
    waitDone(cyc, fv);
    checkOutput("queue_drained_t5", 32'(expQ.size()), 32'd0);

    $display("[TB] single-pixel tile build");
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h5A;
    expQ1.push_back({1'b1, 8'h5A});
    @(negedge Clk);
    checkOutput("d1_we", 32'(bus1.sram_we), 32'd1);
    checkOutput("d1_wr_addr", 32'(bus1.sram_addr), 32'd0);
    checkOutput("d1_wr_data", 32'(bus1.sram_din), 32'h5A);
    @(posedge Clk); #1;
    bus1.in_valid = 1'b0;
    @(negedge Clk);
    checkOutput("d1_loaded", 32'(bus1.loaded), 32'd1);
    checkOutput("d1_in_ready", 32'(bus1.in_ready), 32'd0);
    @(posedge Clk); #1;
    bus1.rd_start = 1'b1;
    @(posedge Clk); #1;
    bus1.rd_start = 1'b0;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!bus1.done && cyc < 50);
    if (!bus1.done) failNow("d1_done_timeout");
    checkOutput("d1_drain_cycles", 32'(cyc), 32'd4);
    checkOutput("d1_beats", 32'(beats1), 32'd1);
    @(posedge Clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
